arc4_crack_range: RTL and testbench

Parametrised ARC4 key-search controller, the successor to the single-range 24-bit cracker. It sweeps candidate keys from `start_key` to `end_key` in steps of `KEY_STEP`, so several instances can split one keyspace by offset/stride. It drives an external ARC4 core and its plaintext memory, and accepts a candidate only if the length-prefixed plaintext is non-empty and fully within a printable character range. Compared with the previous generation it adds a bounded range, generic key width, abort, exhaustion reporting and a tried-key counter.

---
 rtl/arc4_crack_range.sv | 197 +++++++++++++++++++
 tb/tb_arc4_crack_range.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_crack_range.sv
// arc4_crack_range: strided, bounded ARC4 key-search controller.
// Drives an external ARC4 core and its plaintext memory, and accepts the first
// candidate whose length-prefixed plaintext is non-empty and fully printable.
module arc4_crack_range #(
  parameter int unsigned KEY_W    = 24,
  parameter int unsigned KEY_STEP = 1,
  parameter logic [7:0]  CHAR_LO  = 8'h20,
  parameter logic [7:0]  CHAR_HI  = 8'h7E
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             abort,
  output logic             rdy,
  input  logic [KEY_W-1:0] start_key,
  input  logic [KEY_W-1:0] end_key,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             exhausted,
  output logic [31:0]      keys_tried,
  output logic             a4_rst,
  output logic             a4_en,
  input  logic             a4_rdy,
  output logic             pt_sel,
  output logic [7:0]       pt_addr,
  input  logic [7:0]       pt_rddata,
  input  logic [7:0]       copy_pt_addr
);

  localparam int unsigned NK_W  = KEY_W + 1;
  localparam int unsigned CNT_W = 32;
  localparam logic [NK_W-1:0] STEP_EXT = NK_W'(KEY_STEP);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ARST, S_ASTART, S_ABUSY, S_AWAIT, S_RLEN,
    S_LWAIT, S_CHK, S_CWAIT, S_NEXT, S_FOUND, S_FAIL
  } state_t;

  state_t           r_state, w_state_n;
  logic [KEY_W-1:0] r_key, w_key_n;
  logic [KEY_W-1:0] r_start, w_start_n;
  logic [KEY_W-1:0] r_end, w_end_n;
  logic [CNT_W-1:0] r_tried, w_tried_n, w_tried_inc;
  logic [7:0]       r_len, w_len_n;
  logic [7:0]       r_idx, w_idx_n;
  logic [7:0]       r_pt_addr, w_pt_addr_n;
  logic             r_valid, w_valid_n;
  logic             r_exh, w_exh_n;
  logic             r_rdy, w_rdy_n;
  logic             r_a4_rst, w_a4_rst_n;
  logic             r_a4_en, w_a4_en_n;
  logic             r_pt_sel, w_pt_sel_n;
  logic [NK_W-1:0]  w_nk;
  logic             w_searching;
  logic             w_abort_hit;
  logic             w_byte_bad;

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    w_state_n   = r_state;
    w_key_n     = r_key;
    w_start_n   = r_start;
    w_end_n     = r_end;
    w_tried_n   = r_tried;
    w_len_n     = r_len;
    w_idx_n     = r_idx;
    w_valid_n   = r_valid;
    w_exh_n     = r_exh;
    w_nk        = {1'b0, r_key} + STEP_EXT;
    w_tried_inc = (&r_tried) ? r_tried : r_tried + CNT_W'(1);
    w_searching = !(r_state inside {S_IDLE, S_FOUND, S_FAIL});
    w_abort_hit = abort && w_searching;
    w_byte_bad  = (pt_rddata < CHAR_LO) || (pt_rddata > CHAR_HI);

    case (r_state)
      S_IDLE, S_FOUND, S_FAIL: begin
        if (en) begin
          w_start_n = start_key;
          w_end_n   = end_key;
          w_key_n   = start_key;
          w_valid_n = 1'b0;
          w_exh_n   = 1'b0;
          w_tried_n = '0;
          w_state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (r_start > r_end) begin
          w_exh_n   = 1'b1;
          w_state_n = S_FAIL;
        end else begin
          w_state_n = S_ARST;
        end
      end
      S_ARST:   w_state_n = S_ASTART;
      S_ASTART: w_state_n = S_ABUSY;
      S_ABUSY:  if (!a4_rdy) w_state_n = S_AWAIT;
      S_AWAIT:  if (a4_rdy) w_state_n = S_RLEN;
      S_RLEN:   w_state_n = S_LWAIT;
      S_LWAIT: begin
        w_len_n = pt_rddata;
        if (pt_rddata == 8'd0) begin
          w_state_n = S_NEXT;
        end else begin
          w_idx_n   = 8'd1;
          w_state_n = S_CHK;
        end
      end
      S_CHK:    w_state_n = S_CWAIT;
      S_CWAIT: begin
        if (w_byte_bad) begin
          w_state_n = S_NEXT;
        end else if (r_idx == r_len) begin
          w_tried_n = w_tried_inc;
          w_valid_n = 1'b1;
          w_state_n = S_FOUND;
        end else begin
          w_idx_n   = r_idx + 8'd1;
          w_state_n = S_CHK;
        end
      end
      S_NEXT: begin
        w_tried_n = w_tried_inc;
        // Stop at the inclusive end or on carry out of the key space.
        if ((w_nk > {1'b0, r_end}) || w_nk[NK_W-1]) begin
          w_exh_n   = 1'b1;
          w_state_n = S_FAIL;
        end else begin
          w_key_n   = w_nk[KEY_W-1:0];
          w_state_n = S_ARST;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_abort_hit) begin
      w_state_n = S_IDLE;
      w_valid_n = 1'b0;
      w_exh_n   = 1'b0;
      w_tried_n = r_tried;
      w_key_n   = r_key;
    end

    w_a4_rst_n  = (w_state_n == S_ARST) || w_abort_hit;
    w_a4_en_n   = (w_state_n == S_ASTART);
    w_rdy_n     = w_state_n inside {S_IDLE, S_FOUND, S_FAIL};
    w_pt_sel_n  = w_state_n inside {S_RLEN, S_LWAIT, S_CHK, S_CWAIT, S_FOUND};
    w_pt_addr_n = (w_state_n == S_CHK) ? w_idx_n : 8'd0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_key     <= '0;
      r_start   <= '0;
      r_end     <= '0;
      r_tried   <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_pt_addr <= '0;
      r_valid   <= 1'b0;
      r_exh     <= 1'b0;
      r_rdy     <= 1'b1;
      r_a4_rst  <= 1'b0;
      r_a4_en   <= 1'b0;
      r_pt_sel  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_key     <= w_key_n;
      r_start   <= w_start_n;
      r_end     <= w_end_n;
      r_tried   <= w_tried_n;
      r_len     <= w_len_n;
      r_idx     <= w_idx_n;
      r_pt_addr <= w_pt_addr_n;
      r_valid   <= w_valid_n;
      r_exh     <= w_exh_n;
      r_rdy     <= w_rdy_n;
      r_a4_rst  <= w_a4_rst_n;
      r_a4_en   <= w_a4_en_n;
      r_pt_sel  <= w_pt_sel_n;
    end
  end

  assign rdy        = r_rdy;
  assign key        = r_key;
  assign key_valid  = r_valid;
  assign exhausted  = r_exh;
  assign keys_tried = r_tried;
  assign a4_rst     = r_a4_rst;
  assign a4_en      = r_a4_en;
  assign pt_sel     = r_pt_sel;
  // Found-key readout lets the host walk the plaintext combinationally.
  assign pt_addr    = (r_state == S_FOUND) ? copy_pt_addr : r_pt_addr;

endmodule

// File: tb/tb_arc4_crack_range.sv
// Bench for arc4_crack_range: three instances (step 1, step 4, 8-bit/step 2)
// share one ARC4 stub and plaintext memory; only the selected one is driven.
module tb_arc4_crack_range;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] start_key = '0;
  logic [23:0] end_key = '0;
  logic [7:0]  copy_pt_addr = '0;
  logic        a4_rdy;
  logic [7:0]  pt_rddata;
  int          sel = 0;

  logic        en0, en1, en2, ab0, ab1, ab2;
  logic        rdy0, rdy1, rdy2, kv0, kv1, kv2, ex0, ex1, ex2;
  logic [23:0] key0, key1;
  logic [7:0]  key2;
  logic [31:0] kt0, kt1, kt2;
  logic        ar0, ar1, ar2, ae0, ae1, ae2, ps0, ps1, ps2;
  logic [7:0]  pa0, pa1, pa2;

  logic        w_rdy, w_valid, w_exh, w_pt_sel, w_a4_rst, w_a4_en;
  logic [23:0] w_key;
  logic [31:0] w_tried;
  logic [7:0]  w_pt_addr;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int rst_cnt = 0;

  logic [7:0] ptab [longint];
  logic [7:0] ptmem [256];
  int         busy_cnt;
  longint     run_key;

  always #5 clk = ~clk;

  assign en0 = en && (sel == 0);
  assign en1 = en && (sel == 1);
  assign en2 = en && (sel == 2);
  assign ab0 = abort && (sel == 0);
  assign ab1 = abort && (sel == 1);
  assign ab2 = abort && (sel == 2);

  arc4_crack_range #(.KEY_W(24), .KEY_STEP(1)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .abort(ab0), .rdy(rdy0),
    .start_key(start_key), .end_key(end_key), .key(key0), .key_valid(kv0),
    .exhausted(ex0), .keys_tried(kt0), .a4_rst(ar0), .a4_en(ae0),
    .a4_rdy(a4_rdy), .pt_sel(ps0), .pt_addr(pa0), .pt_rddata(pt_rddata),
    .copy_pt_addr(copy_pt_addr));

  arc4_crack_range #(.KEY_W(24), .KEY_STEP(4)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .abort(ab1), .rdy(rdy1),
    .start_key(start_key), .end_key(end_key), .key(key1), .key_valid(kv1),
    .exhausted(ex1), .keys_tried(kt1), .a4_rst(ar1), .a4_en(ae1),
    .a4_rdy(a4_rdy), .pt_sel(ps1), .pt_addr(pa1), .pt_rddata(pt_rddata),
    .copy_pt_addr(copy_pt_addr));

  arc4_crack_range #(.KEY_W(8), .KEY_STEP(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .abort(ab2), .rdy(rdy2),
    .start_key(start_key[7:0]), .end_key(end_key[7:0]), .key(key2),
    .key_valid(kv2), .exhausted(ex2), .keys_tried(kt2), .a4_rst(ar2),
    .a4_en(ae2), .a4_rdy(a4_rdy), .pt_sel(ps2), .pt_addr(pa2),
    .pt_rddata(pt_rddata), .copy_pt_addr(copy_pt_addr));

  // Route the selected instance's outputs to the shared observation signals.
  always_comb begin
    case (sel)
      1: begin
        w_rdy = rdy1; w_valid = kv1; w_exh = ex1; w_key = key1;
        w_tried = kt1; w_pt_sel = ps1; w_pt_addr = pa1;
      end
      2: begin
        w_rdy = rdy2; w_valid = kv2; w_exh = ex2; w_key = {16'd0, key2};
        w_tried = kt2; w_pt_sel = ps2; w_pt_addr = pa2;
      end
      default: begin
        w_rdy = rdy0; w_valid = kv0; w_exh = ex0; w_key = key0;
        w_tried = kt0; w_pt_sel = ps0; w_pt_addr = pa0;
      end
    endcase
  end

  assign w_a4_rst = ar0 | ar1 | ar2;
  assign w_a4_en  = ae0 | ae1 | ae2;

  // Plaintext for a key: absent keys decode to length 1 holding 0x00.
  function automatic logic [7:0] pt_lookup(input longint k, input int i);
    longint idx;
    idx = k * 256 + longint'(i);
    if (ptab.exists(idx)) return ptab[idx];
    return (i == 0) ? 8'd1 : 8'd0;
  endfunction

  // Acceptance rule: non-empty and every byte printable.
  function automatic bit accept(input longint k);
    int len;
    logic [7:0] b;
    len = int'(pt_lookup(k, 0));
    if (len == 0) return 1'b0;
    for (int i = 1; i <= len; i++) begin
      b = pt_lookup(k, i);
      if (b < 8'h20 || b > 8'h7E) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference: walk the arithmetic key sequence and stop at the first hit.
  task automatic model(input longint s, input longint e, input longint step,
                       input int kw, output bit found, output longint k,
                       output longint tried);
    longint lim;
    found = 1'b0; tried = 0; k = s;
    lim = longint'(1) << kw;
    if (s > e) return;
    for (longint c = s; c <= e && c < lim; c += step) begin
      k = c;
      tried++;
      if (accept(c)) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  // ARC4 core stub: busy for a few cycles, then publishes the key's plaintext.
  always @(posedge clk) begin
    if (rst || w_a4_rst) begin
      a4_rdy   <= 1'b1;
      busy_cnt <= 0;
    end else if (w_a4_en) begin
      a4_rdy   <= 1'b0;
      busy_cnt <= int'($urandom_range(1, 4));
      run_key  <= longint'(w_key);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        a4_rdy <= 1'b1;
        for (int i = 0; i < 256; i++) ptmem[i] <= pt_lookup(run_key, i);
      end
    end
  end

  // Plaintext memory with one cycle of read latency.
  always @(posedge clk) pt_rddata <= ptmem[w_pt_addr];

  // Pulse counters for the ARC4 control strobes.
  always @(posedge clk) begin
    if (w_a4_en) en_cnt <= en_cnt + 1;
    if (w_a4_rst) rst_cnt <= rst_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_search(input int s, input logic [23:0] sk, input logic [23:0] ek,
                            output int cyc);
    bit done;
    sel = s; start_key = sk; end_key = ek;
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    chk("rdy_fall", 64'(w_rdy), 64'd0);
    chk("valid_clr", 64'(w_valid), 64'd0);
    done = 1'b0; cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      if (w_rdy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("search_done", 64'(done), 64'd1);
  endtask

  task automatic check_result(input string tag, input int s, input logic [23:0] sk,
                              input logic [23:0] ek);
    bit found;
    longint mk, mt, step;
    int kw;
    step = (s == 1) ? 4 : (s == 2) ? 2 : 1;
    kw   = (s == 2) ? 8 : 24;
    model(longint'(sk), longint'(ek), step, kw, found, mk, mt);
    chk({tag, "_key"}, 64'(w_key), 64'(mk));
    chk({tag, "_valid"}, 64'(w_valid), 64'(found));
    chk({tag, "_exh"}, 64'(w_exh), 64'(!found));
    chk({tag, "_tried"}, 64'(w_tried), 64'(mt));
  endtask

  task automatic load_hello();
    ptab.delete();
    ptab[10*256+0] = 8'd5;
    ptab[10*256+1] = 8'h48;
    ptab[10*256+2] = 8'h65;
    ptab[10*256+3] = 8'h6C;
    ptab[10*256+4] = 8'h6C;
    ptab[10*256+5] = 8'h6F;
  endtask

  initial begin
    int cyc, base, saved;
    bit hit;
    logic [23:0] sk, ek;
    int len, r;
    logic [7:0] b;

    for (int i = 0; i < 256; i++) ptmem[i] = 8'd0;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_rdy", 64'(w_rdy), 64'd1);
    chk("rst_key", 64'(w_key), 64'd0);
    chk("rst_valid", 64'(w_valid), 64'd0);
    chk("rst_exh", 64'(w_exh), 64'd0);
    chk("rst_tried", 64'(w_tried), 64'd0);
    chk("rst_a4", 64'({w_a4_rst, w_a4_en, w_pt_sel}), 64'd0);
    chk("rst_addr", 64'(w_pt_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Found case, then readout through copy_pt_addr.
    load_hello();
    run_search(0, 24'd0, 24'hFF, cyc);
    check_result("hello", 0, 24'd0, 24'hFF);
    chk("hello_key_lit", 64'(w_key), 64'h0A);
    chk("hello_tried_lit", 64'(w_tried), 64'd11);
    chk("hello_ptsel", 64'(w_pt_sel), 64'd1);
    copy_pt_addr = 8'd1;
    #1;
    chk("copy_addr", 64'(w_pt_addr), 64'd1);
    @(negedge clk);
    chk("copy_data", 64'(pt_rddata), 64'h48);
    copy_pt_addr = 8'd0;

    // Restart directly from the found state.
    run_search(0, 24'd0, 24'hFF, cyc);
    check_result("restart", 0, 24'd0, 24'hFF);

    // Stride with no match.
    ptab.delete();
    run_search(1, 24'd3, 24'd10, cyc);
    check_result("stride", 1, 24'd3, 24'd10);
    chk("stride_key_lit", 64'(w_key), 64'd7);
    chk("stride_tried_lit", 64'(w_tried), 64'd2);

    // Rejection rules: len 0, 0x7F, 0x1F rejected; 0x20 and 0x7E accepted.
    ptab.delete();
    ptab[0*256+0] = 8'd0;
    ptab[1*256+0] = 8'd1; ptab[1*256+1] = 8'h7F;
    ptab[2*256+0] = 8'd1; ptab[2*256+1] = 8'h1F;
    ptab[3*256+0] = 8'd2; ptab[3*256+1] = 8'h20; ptab[3*256+2] = 8'h7E;
    run_search(0, 24'd0, 24'd10, cyc);
    check_result("reject", 0, 24'd0, 24'd10);
    chk("reject_key_lit", 64'(w_key), 64'd3);

    // Top of an 8-bit key space must not wrap.
    ptab.delete();
    run_search(2, 24'hFE, 24'hFF, cyc);
    check_result("wrap", 2, 24'hFE, 24'hFF);
    chk("wrap_tried_lit", 64'(w_tried), 64'd1);

    // Inverted range fails quickly with no ARC4 start.
    base = en_cnt;
    run_search(0, 24'd5, 24'd4, cyc);
    chk("inv_fast", 64'(cyc <= 1), 64'd1);
    chk("inv_exh", 64'(w_exh), 64'd1);
    chk("inv_tried", 64'(w_tried), 64'd0);
    chk("inv_key", 64'(w_key), 64'd5);
    chk("inv_no_a4en", 64'(en_cnt), 64'(base));

    // Abort while the core is busy on the third candidate.
    load_hello();
    sel = 0; start_key = 24'd0; end_key = 24'hFF;
    base = en_cnt;
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (w_a4_en && en_cnt == base + 2) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reach", 64'(hit), 64'd1);
    @(negedge clk);
    abort = 1'b1;
    saved = rst_cnt;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_rdy", 64'(w_rdy), 64'd1);
    chk("abort_a4rst", 64'(w_a4_rst), 64'd1);
    chk("abort_flags", 64'({w_valid, w_exh}), 64'd0);
    chk("abort_tried", 64'(w_tried), 64'd2);
    @(negedge clk);
    chk("abort_a4rst_end", 64'(w_a4_rst), 64'd0);
    chk("abort_one_pulse", 64'(rst_cnt), 64'(saved + 1));

    // Asynchronous reset in the middle of a byte check.
    load_hello();
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (w_pt_sel && w_pt_addr == 8'd1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("chk_reach", 64'(hit), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rdy", 64'(w_rdy), 64'd1);
    chk("arst_key", 64'(w_key), 64'd0);
    chk("arst_tried", 64'(w_tried), 64'd0);
    chk("arst_outs", 64'({w_valid, w_exh, w_a4_rst, w_a4_en, w_pt_sel}), 64'd0);
    chk("arst_addr", 64'(w_pt_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomised ranges and plaintexts across all three instances.
    for (int t = 0; t < 9; t++) begin
      sel = t % 3;
      if (sel == 2) begin
        sk = 24'($urandom_range(200, 255));
        ek = 24'($urandom_range(int'(sk), 255));
      end else begin
        sk = 24'($urandom_range(0, 1000));
        ek = sk + 24'($urandom_range(0, 16));
      end
      ptab.delete();
      for (longint k = longint'(sk); k <= longint'(ek); k++) begin
        len = int'($urandom_range(0, 4));
        ptab[k*256] = 8'(len);
        for (int i = 1; i <= len; i++) begin
          r = int'($urandom_range(0, 99));
          if (r < 85) b = 8'($urandom_range(32, 126));
          else case (r % 4)
            0: b = 8'h1F;
            1: b = 8'h7F;
            2: b = 8'h00;
            default: b = 8'hFF;
          endcase
          ptab[k*256 + longint'(i)] = b;
        end
      end
      run_search(sel, sk, ek, cyc);
      check_result("rand", sel, sk, ek);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
